nand_phy_rd_capture: RTL and testbench

NAND_PHY_RD_CAPTURE -- requirements
Module: nand_phy_rd_capture

---
 rtl/nand_phy_pkg.sv | 20 ++
 rtl/nand_phy_rd_fifo.sv | 60 ++++++
 rtl/nand_phy_rd_capture.sv | 122 ++++++++++++
 tb/tb_nand_phy_rd_capture.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_phy_pkg.sv
// Shared definitions for the NAND PHY read-capture path: FSM state encoding
// and default data-path widths.
package nand_phy_pkg;

    // Default number of NAND DQ bits.
    localparam int DQ_WIDTH_DEF = 8;

    // Default width of one captured word.
    // Each word is {fall,rise}, so it is twice the DQ width.
    localparam int WORD_WIDTH = 2 * DQ_WIDTH_DEF;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LAT = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/nand_phy_rd_fifo.sv
// Synchronous first-word-fall-through FIFO for captured read words.
// The head word is driven combinationally from storage, so a word pushed in
// one cycle is visible in the next. The output reads 0 whenever the FIFO is empty.
// Pointers carry one extra wrap bit. Equal pointers mean the FIFO is empty.
// Pointers that differ only in the wrap bit mean the FIFO is full.
module nand_phy_rd_fifo
    import nand_phy_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 8            // must be a power of 2, at least 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // When the FIFO is full, a pop in the same cycle frees the slot that this push takes.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Word storage write.
    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/nand_phy_rd_capture.sv
// NAND PHY read-data capture.
// After a programmable latency, the block captures rd_len consecutive
// {fall,rise} DQ words into an FWFT FIFO. The NAND side is never stalled.
// A word that arrives when the FIFO is full is dropped, and the sticky overflow flag is set.
module nand_phy_rd_capture
    import nand_phy_pkg::*;
#(
    parameter int DQ_WIDTH   = DQ_WIDTH_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  rd_start,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    input  logic [3:0]            rd_lat,
    input  logic [DQ_WIDTH-1:0]   rd_data_rise,
    input  logic [DQ_WIDTH-1:0]   rd_data_fall,
    output logic [2*DQ_WIDTH-1:0] rdo_data,
    output logic                  rdo_valid,
    input  logic                  rdo_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    state_t               r_state;
    logic [3:0]           r_lat_cnt;
    logic [LEN_WIDTH-1:0] r_rem;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;

    assign w_push = (r_state == ST_CAPTURE);
    assign w_pop  = rdo_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    assign rdo_valid = !w_empty;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;

    // Capture sequencer; busy and done are registered alongside the state.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here keep every branch reading pre-edge state.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rd_start) begin
                        r_rem  <= rd_len;
                        r_busy <= 1'b1;
                        if (rd_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (rd_lat == 4'd0) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state   <= ST_WAIT_LAT;
                            r_lat_cnt <= rd_lat - 4'd1;
                        end
                    end
                end
                ST_WAIT_LAT: begin
                    if (r_lat_cnt == 4'd0) r_state <= ST_CAPTURE;
                    else                   r_lat_cnt <= r_lat_cnt - 4'd1;
                end
                ST_CAPTURE: begin
                    // The count down to 1 means an all-ones rd_len never wraps.
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == LEN_WIDTH'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk0) begin
        if (rst0)              r_overflow <= 1'b0;
        else if (w_drop)       r_overflow <= 1'b1;
        else if (clr_overflow) r_overflow <= 1'b0;
    end

    nand_phy_rd_fifo #(
        .WIDTH (2 * DQ_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk0),
        .i_rst       (rst0),
        .i_push      (w_push),
        .i_push_data ({rd_data_fall, rd_data_rise}),
        .o_full      (w_full),
        .i_pop       (rdo_ready),
        .o_empty     (w_empty),
        .o_rd_data   (rdo_data)
    );

endmodule

// File: tb/tb_nand_phy_rd_capture.sv
// Directed bench for nand_phy_rd_capture (DQ_WIDTH=8, FIFO_DEPTH=8).
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that same point.
// The variable cyc numbers the cycle that is in progress.
// The DQ ramp presents rise=0x10+j and fall=0x20+j in cycle data_base+j.
module tb_nand_phy_rd_capture;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        rd_start;
    logic [15:0] rd_len;
    logic [3:0]  rd_lat;
    logic [7:0]  rd_data_rise;
    logic [7:0]  rd_data_fall;
    logic [15:0] rdo_data;
    logic        rdo_valid;
    logic        rdo_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        clr_overflow;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int data_base = 0;
    int k;

    nand_phy_rd_capture #(
        .DQ_WIDTH   (8),
        .FIFO_DEPTH (8),
        .LEN_WIDTH  (16)
    ) dut (
        .clk0         (clk0),
        .rst0         (rst0),
        .rd_start     (rd_start),
        .rd_len       (rd_len),
        .rd_lat       (rd_lat),
        .rd_data_rise (rd_data_rise),
        .rd_data_fall (rd_data_fall),
        .rdo_data     (rdo_data),
        .rdo_valid    (rdo_valid),
        .rdo_ready    (rdo_ready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk0 = ~clk0;

    function automatic logic [15:0] word_of(input int j);
        logic [7:0] f;
        logic [7:0] r;
        f = 8'(32'h20 + j);
        r = 8'(32'h10 + j);
        return {f, r};
    endfunction

    task automatic drive_data();
        logic [15:0] w;
        w = word_of(cyc - data_base);
        rd_data_fall = w[15:8];
        rd_data_rise = w[7:0];
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk0);
            #1;
            cyc++;
            drive_data();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse rd_start in the current cycle; returns in the following cycle.
    task automatic start(input logic [15:0] len, input logic [3:0] lat);
        rd_start = 1'b1;
        rd_len   = len;
        rd_lat   = lat;
        step(1);
        rd_start = 1'b0;
        rd_len   = 16'hFFFF;
        rd_lat   = 4'hF;
    endtask

    initial begin
        rst0         = 1'b1;
        rd_start     = 1'b0;
        rd_len       = '0;
        rd_lat       = '0;
        rdo_ready    = 1'b0;
        clr_overflow = 1'b0;
        drive_data();

        // Reset state
        step(3);
        check("rst_busy",     busy,      0);
        check("rst_done",     done,      0);
        check("rst_overflow", overflow,  0);
        check("rst_valid",    rdo_valid, 0);
        check("rst_data",     rdo_data,  0);
        rst0 = 1'b0;
        step(1);
        check("idle_busy", busy, 0);

        // Basic burst: len=4, lat=3, ready held high
        rdo_ready = 1'b1;
        data_base = cyc + 4;
        start(16'd4, 4'd3);                    // now T+1
        check("b1_busy_t1", busy, 1);
        check("b1_done_t1", done, 0);
        step(3);                               // T+4
        check("b1_valid_t4", rdo_valid, 0);
        step(1);                               // T+5
        check("b1_valid_t5", rdo_valid, 1);
        check("b1_w0", rdo_data, 16'h2010);
        step(1);
        check("b1_w1", rdo_data, 16'h2111);
        step(1);
        check("b1_w2", rdo_data, 16'h2212);
        check("b1_done_t7", done, 0);
        step(1);                               // T+8
        check("b1_w3", rdo_data, 16'h2313);
        check("b1_done_t8", done, 1);
        step(1);
        check("b1_done_t9",  done,      0);
        check("b1_busy_t9",  busy,      0);
        check("b1_valid_t9", rdo_valid, 0);

        // Zero-length burst
        start(16'd0, 4'd5);                    // T+1
        check("z_done_t1",  done,      1);
        check("z_busy_t1",  busy,      1);
        check("z_valid_t1", rdo_valid, 0);
        step(1);
        check("z_done_t2",  done,      0);
        check("z_busy_t2",  busy,      0);
        check("z_valid_t2", rdo_valid, 0);

        // Overflow: len=10 with the consumer stalled
        rdo_ready = 1'b0;
        data_base = cyc + 1;
        start(16'd10, 4'd0);                   // T+1
        step(8);                               // T+9
        check("ov_pre", overflow, 0);
        step(1);                               // T+10
        check("ov_set", overflow, 1);
        step(1);                               // T+11
        check("ov_done",  done,      1);
        check("ov_valid", rdo_valid, 1);
        check("ov_head",  rdo_data,  16'h2010);
        step(1);                               // T+12
        check("ov_hold", rdo_data, 16'h2010);
        check("ov_idle", busy,     0);
        rdo_ready = 1'b1;
        k = 0;
        repeat (12) begin
            if (rdo_valid) begin
                check("ov_drain_word", rdo_data, word_of(k));
                k++;
            end
            step(1);
        end
        check("ov_drain_count", k,         8);
        check("ov_drain_empty", rdo_valid, 0);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        check("ov_clr", overflow, 0);

        // Full FIFO with simultaneous push and pop: len=12
        rdo_ready = 1'b0;
        data_base = cyc + 1;
        start(16'd12, 4'd0);                   // T+1
        step(8);                               // T+9, FIFO full
        check("fp_valid", rdo_valid, 1);
        rdo_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            check("fp_word_valid", rdo_valid, 1);
            check("fp_word", rdo_data, word_of(j));
            if (j == 4) check("fp_done", done, 1);
            step(1);
        end
        check("fp_empty", rdo_valid, 0);
        check("fp_no_ov", overflow,  0);

        // Reset during CAPTURE of a len=6 burst
        rdo_ready = 1'b0;
        data_base = cyc + 1;
        start(16'd6, 4'd0);                    // T+1
        step(2);                               // T+3
        check("rb_busy_pre",  busy,      1);
        check("rb_valid_pre", rdo_valid, 1);
        rst0 = 1'b1;
        step(1);                               // T+4
        rst0 = 1'b0;
        check("rb_busy",  busy,      0);
        check("rb_valid", rdo_valid, 0);
        check("rb_done",  done,      0);
        check("rb_data",  rdo_data,  0);
        repeat (4) begin
            step(1);
            check("rb_no_done",  done,      0);
            check("rb_no_valid", rdo_valid, 0);
        end

        // rd_start during WAIT_LAT is ignored
        rdo_ready = 1'b1;
        data_base = cyc + 5;
        start(16'd2, 4'd4);                    // T+1
        step(1);                               // T+2, WAIT_LAT
        rd_start = 1'b1;
        rd_len   = 16'd5;
        rd_lat   = 4'd0;
        step(1);                               // T+3
        rd_start = 1'b0;
        step(1);                               // T+4
        check("ig_valid_t4", rdo_valid, 0);
        step(1);                               // T+5
        check("ig_valid_t5", rdo_valid, 0);
        step(1);                               // T+6
        check("ig_w0", rdo_data, 16'h2010);
        step(1);                               // T+7
        check("ig_w1",   rdo_data, 16'h2111);
        check("ig_done", done,     1);
        step(1);                               // T+8
        check("ig_busy_t8",  busy,      0);
        check("ig_valid_t8", rdo_valid, 0);
        step(1);
        check("ig_busy_t9", busy, 0);

        // A set and a clear of overflow in the same cycle: the set wins
        rdo_ready = 1'b0;
        data_base = cyc + 1;
        start(16'd10, 4'd0);                   // T+1
        step(8);                               // T+9
        check("sw_pre", overflow, 0);
        step(1);                               // T+10, a push is dropped this cycle
        check("sw_set", overflow, 1);
        clr_overflow = 1'b1;
        step(1);                               // T+11
        clr_overflow = 1'b0;
        check("sw_set_wins", overflow, 1);
        check("sw_done",     done,     1);
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        check("sw_clr", overflow, 0);
        rdo_ready = 1'b1;
        k = 0;
        repeat (12) begin
            if (rdo_valid) begin
                check("sw_drain_word", rdo_data, word_of(k));
                k++;
            end
            step(1);
        end
        check("sw_drain_count", k, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
